// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer note sequencer: table entry field
// positions, sequencer state encoding and the ms prescaler derivation.
package buzzer_pkg;

    localparam int NOTE_HI = 31;
    localparam int NOTE_LO = 24;
    localparam int VELO_HI = 23;
    localparam int VELO_LO = 16;
    localparam int TIME_HI = 15;
    localparam int TIME_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        ADVANCE,
        DONE
    } state_t;

    function automatic int tick_div(input int clk_fre);
        return clk_fre / 1000;
    endfunction

    // A prescaler of one cycle per ms still needs a 1-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the last count; synchronous clear restarts at 0.
module ms_tick_gen
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note table scheduler feeding the buzzer tone generator.
// Optional NOTE_SEQ_PAUSE_EN adds a pause input that freezes PLAY/GAP timing.
module note_sequencer
    import buzzer_pkg::*;
#(
    parameter int CLK_FRE = 50000000,
    parameter int DEPTH   = 48,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef NOTE_SEQ_PAUSE_EN
    input  logic          pause,
`endif
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] len,
    input  logic [7:0]    loop_cnt,
    input  logic [15:0]   gap_ms,
    output logic [AW-1:0] tbl_addr,
    input  logic [31:0]   tbl_data,
    output logic [7:0]    note,
    output logic [7:0]    velocity,
    output logic          tone_en,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pos
);

    localparam int TICK_DIV = tick_div(CLK_FRE);

    state_t        r_state;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_pos;
    logic [7:0]    r_loop_cnt;
    logic [7:0]    r_loops;
    logic [15:0]   r_gap;
    logic [15:0]   r_dur;
    logic [15:0]   r_ms;
    logic [7:0]    r_note;
    logic [7:0]    r_vel;
    logic          r_tone_en;
    logic          r_busy;
    logic          r_done;

    logic          w_pause;
    logic          w_run;
    logic          w_tick;
    logic          w_ms_last;
    logic          w_seg_end;
    logic          w_clr;
    logic [AW:0]   w_pos_inc;
    logic          w_pass_end;
    logic          w_last_loop;

`ifdef NOTE_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // One prescaler serves both PLAY and GAP; it restarts on LOAD and on PLAY exit.
    assign w_run       = ((r_state == PLAY) || (r_state == GAP)) && !w_pause;
    assign w_ms_last   = (r_state == GAP) ? (r_ms == r_gap - 16'd1) : (r_ms == r_dur - 16'd1);
    assign w_seg_end   = w_run && w_tick && w_ms_last;
    assign w_clr       = (r_state == LOAD) || w_seg_end;
    assign w_pos_inc   = {1'b0, r_pos} + {{AW{1'b0}}, 1'b1};
    assign w_pass_end  = (w_pos_inc == {1'b0, r_len});
    assign w_last_loop = (r_loop_cnt != 8'd0) && (({1'b0, r_loops} + 9'd1) == {1'b0, r_loop_cnt});

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_clr),
        .i_en   (w_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_pos      <= '0;
            r_loop_cnt <= '0;
            r_loops    <= '0;
            r_gap      <= '0;
            r_dur      <= '0;
            r_ms       <= '0;
            r_note     <= '0;
            r_vel      <= '0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state   <= IDLE;
                r_tone_en <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && (len != '0)) begin
                            r_len      <= len;
                            r_loop_cnt <= loop_cnt;
                            r_gap      <= gap_ms;
                            r_pos      <= '0;
                            r_loops    <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                    FETCH: r_state <= LOAD;
                    LOAD: begin
                        r_note <= tbl_data[NOTE_HI:NOTE_LO];
                        r_vel  <= tbl_data[VELO_HI:VELO_LO];
                        r_dur  <= tbl_data[TIME_HI:TIME_LO];
                        if (tbl_data[TIME_HI:TIME_LO] == 16'd0) begin
                            r_state <= ADVANCE;
                        end else begin
                            r_ms      <= '0;
                            r_tone_en <= (tbl_data[NOTE_HI:NOTE_LO] != 8'd0);
                            r_state   <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (w_seg_end) begin
                            r_tone_en <= 1'b0;
                            r_ms      <= '0;
                            r_state   <= (r_gap != 16'd0) ? GAP : ADVANCE;
                        end else begin
                            if (w_run && w_tick) r_ms <= r_ms + 16'd1;
                            r_tone_en <= (r_note != 8'd0) && !w_pause;
                        end
                    end
                    GAP: begin
                        if (w_seg_end) begin
                            r_state <= ADVANCE;
                        end else if (w_run && w_tick) begin
                            r_ms <= r_ms + 16'd1;
                        end
                    end
                    ADVANCE: begin
                        if (w_pass_end) begin
                            if (w_last_loop) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_pos   <= '0;
                                if (r_loops != 8'hFF) r_loops <= r_loops + 8'd1;
                                r_state <= FETCH;
                            end
                        end else begin
                            r_pos   <= r_pos + 1'b1;
                            r_state <= FETCH;
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tbl_addr = r_pos;
    assign pos      = r_pos;
    assign note     = r_note;
    assign velocity = r_vel;
    assign tone_en  = r_tone_en;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
